// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and fills the IF/ID register.
// Branch redirects beat stalls and replace the fetched word with a NOP bubble.
module if_stage #(
  parameter int unsigned            AddrWidth  = 32,
  parameter int unsigned            InstrWidth = 32,
  parameter logic [AddrWidth-1:0]   ResetPc    = '0,
  parameter int unsigned            PcStep     = 4,
  parameter logic [InstrWidth-1:0]  NopInstr   = InstrWidth'(32'h00000013),
  parameter int unsigned            CntWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [AddrWidth-1:0]  branch_target_i,
  output logic [AddrWidth-1:0]  imem_addr_o,
  input  logic [InstrWidth-1:0] imem_rdata_i,
  output logic [AddrWidth-1:0]  id_pc_o,
  output logic [AddrWidth-1:0]  id_pc_next_o,
  output logic [InstrWidth-1:0] id_instr_o,
  output logic                  id_valid_o,
  output logic [CntWidth-1:0]   fetch_count_o
);

  localparam logic [AddrWidth-1:0] Step      = AddrWidth'(PcStep);
  // PcStep is a power of two, so clearing the bits below it aligns the redirect target.
  localparam logic [AddrWidth-1:0] AlignMask = ~(Step - AddrWidth'(1));

  logic [AddrWidth-1:0]  pc_q, pc_d, pc_inc;
  logic [AddrWidth-1:0]  id_pc_q, id_pc_d;
  logic [AddrWidth-1:0]  id_pc_next_q, id_pc_next_d;
  logic [InstrWidth-1:0] id_instr_q, id_instr_d;
  logic                  id_valid_q, id_valid_d;
  logic [CntWidth-1:0]   fetch_count_q, fetch_count_d;

  assign pc_inc = pc_q + Step;

  always_comb begin
    pc_d          = pc_q;
    id_pc_d       = id_pc_q;
    id_pc_next_d  = id_pc_next_q;
    id_instr_d    = id_instr_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken_i) begin
      pc_d         = branch_target_i & AlignMask;
      id_pc_d      = '0;
      id_pc_next_d = '0;
      id_instr_d   = NopInstr;
      id_valid_d   = 1'b0;
    end else if (!stall_i) begin
      pc_d         = pc_inc;
      id_pc_d      = pc_q;
      id_pc_next_d = pc_inc;
      id_instr_d   = imem_rdata_i;
      id_valid_d   = 1'b1;
      if (fetch_count_q != '1) begin
        fetch_count_d = fetch_count_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= ResetPc;
      id_pc_q       <= '0;
      id_pc_next_q  <= '0;
      id_instr_q    <= NopInstr;
      id_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      id_pc_next_q  <= id_pc_next_d;
      id_instr_q    <= id_instr_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign id_pc_o       = id_pc_q;
  assign id_pc_next_o  = id_pc_next_q;
  assign id_instr_o    = id_instr_q;
  assign id_valid_o    = id_valid_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (default, and wrapping PC with a 2-bit counter) share random
// stimulus and are checked every cycle against a behavioural fetch model plus literal checkpoints.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] target = '0;

  logic [31:0] addr_a, rdata_a, idpc_a, idnext_a, instr_a;
  logic        valid_a;
  logic [15:0] cnt_a;
  logic [31:0] addr_b, rdata_b, idpc_b, idnext_b, instr_b;
  logic        valid_b;
  logic [1:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] Nop = 32'h00000013;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed word at 0, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'h9BDF};
  endfunction

  assign rdata_a = mem(addr_a);
  assign rdata_b = mem(addr_b);

  if_stage dut_a (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(target), .imem_addr_o(addr_a), .imem_rdata_i(rdata_a),
    .id_pc_o(idpc_a), .id_pc_next_o(idnext_a), .id_instr_o(instr_a),
    .id_valid_o(valid_a), .fetch_count_o(cnt_a)
  );

  if_stage #(.ResetPc(32'hFFFFFFF8), .CntWidth(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(target), .imem_addr_o(addr_b), .imem_rdata_i(rdata_b),
    .id_pc_o(idpc_b), .id_pc_next_o(idnext_b), .id_instr_o(instr_b),
    .id_valid_o(valid_b), .fetch_count_o(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  logic [31:0] m_pc[2], m_idpc[2], m_idnext[2], m_instr[2], m_cnt[2];
  logic        m_valid[2];

  function automatic logic [31:0] rst_pc(input int k);
    return (k == 0) ? 32'h0 : 32'hFFFFFFF8;
  endfunction

  function automatic logic [31:0] cnt_max(input int k);
    return (k == 0) ? 32'd65535 : 32'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] <= rst_pc(k); m_idpc[k] <= 0; m_idnext[k] <= 0;
        m_instr[k] <= Nop; m_valid[k] <= 1'b0; m_cnt[k] <= 0;
      end else if (br) begin
        m_pc[k] <= {target[31:2], 2'b00};
        m_idpc[k] <= 0; m_idnext[k] <= 0; m_instr[k] <= Nop; m_valid[k] <= 1'b0;
      end else if (!stall) begin
        m_idpc[k]   <= m_pc[k];
        m_idnext[k] <= m_pc[k] + 32'd4;
        m_pc[k]     <= m_pc[k] + 32'd4;
        m_instr[k]  <= mem(m_pc[k]);
        m_valid[k]  <= 1'b1;
        if (m_cnt[k] < cnt_max(k)) m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("a.imem_addr", addr_a, m_pc[0]);
    check("a.id_pc", idpc_a, m_idpc[0]);
    check("a.id_pc_next", idnext_a, m_idnext[0]);
    check("a.id_instr", instr_a, m_instr[0]);
    check("a.id_valid", 32'(valid_a), 32'(m_valid[0]));
    check("a.fetch_count", 32'(cnt_a), m_cnt[0]);
    check("b.imem_addr", addr_b, m_pc[1]);
    check("b.id_pc", idpc_b, m_idpc[1]);
    check("b.id_pc_next", idnext_b, m_idnext[1]);
    check("b.id_instr", instr_b, m_instr[1]);
    check("b.id_valid", 32'(valid_b), 32'(m_valid[1]));
    check("b.fetch_count", 32'(cnt_b), m_cnt[1]);
  end

  task automatic edge_drive(input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #2;
    stall = s; br = b; target = t;
  endtask

  initial begin
    // Reset held across two edges.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("lit.rst_addr", addr_a, 32'h0);
    check("lit.rst_valid", 32'(valid_a), 32'h0);
    check("lit.rst_instr", instr_a, Nop);
    check("lit.rst_addr_b", addr_b, 32'hFFFFFFF8);
    rst_n = 1'b1;
    // Edge 1: first fetch.
    @(negedge clk);
    check("lit.e1_id_pc", idpc_a, 32'h0);
    check("lit.e1_id_pc_next", idnext_a, 32'h4);
    check("lit.e1_instr", instr_a, 32'h00A00093);
    check("lit.e1_valid", 32'(valid_a), 32'h1);
    check("lit.e1_cnt", 32'(cnt_a), 32'h1);
    check("lit.e1_addr", addr_a, 32'h4);
    // Edge 2: b wraps through FFFFFFFC.
    @(negedge clk);
    check("lit.e2_id_pc", idpc_a, 32'h4);
    check("lit.b_wrap_id_pc", idpc_b, 32'hFFFFFFFC);
    check("lit.b_wrap_next", idnext_b, 32'h0);
    check("lit.b_wrap_addr", addr_b, 32'h0);
    // Stall for edges 3..5 with pc=8.
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("lit.stall_addr", addr_a, 32'h8);
      check("lit.stall_id_pc", idpc_a, 32'h4);
      check("lit.stall_cnt", 32'(cnt_a), 32'h2);
    end
    stall = 1'b0;
    @(negedge clk);
    check("lit.unstall_id_pc", idpc_a, 32'h8);
    check("lit.unstall_addr", addr_a, 32'hC);
    // Branch with stall at pc=12.
    stall = 1'b1; br = 1'b1; target = 32'h00000103;
    @(negedge clk);
    check("lit.br_addr", addr_a, 32'h100);
    check("lit.br_valid", 32'(valid_a), 32'h0);
    check("lit.br_instr", instr_a, Nop);
    check("lit.br_cnt", 32'(cnt_a), 32'h3);
    stall = 1'b0; br = 1'b0;
    @(negedge clk);
    check("lit.br_id_pc", idpc_a, 32'h100);
    check("lit.br_id_valid", 32'(valid_a), 32'h1);
    check("lit.b_sat", 32'(cnt_b), 32'h3);
    // Redirect to 0x20, stall, then drop reset between edges.
    br = 1'b1; target = 32'h20;
    edge_drive(1'b1, 1'b0, 32'h0);
    check("lit.pre_rst_addr", addr_a, 32'h20);
    #1;
    rst_n = 1'b0;
    #1;
    check("lit.async_addr", addr_a, 32'h0);
    check("lit.async_valid", 32'(valid_a), 32'h0);
    check("lit.async_instr", instr_a, Nop);
    check("lit.async_cnt", 32'(cnt_a), 32'h0);
    check("lit.async_addr_b", addr_b, 32'hFFFFFFF8);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("lit.restart_id_pc", idpc_a, 32'h0);
    check("lit.restart_instr", instr_a, 32'h00A00093);
    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) == 0) t = 32'hFFFFFFE0 | (t & 32'h1F);
      edge_drive($urandom_range(3) == 0, $urandom_range(7) == 0, t);
    end
    edge_drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It owns the program counter, drives the instruction-memory address, and latches the fetched instruction into the IF/ID pipeline register consumed by the decode stage. It honours stall requests from the hazard unit and branch redirects from EX. Each redirect squashes the fetched instruction into a NOP bubble.

Parameters:
addr_width, 32, width of PC and instruction address
instr_width, 32, width of an instruction word
reset_pc, 0, PC value loaded on reset
pc_step, 4, PC increment per fetch; power of two
nop_instr, 32'h00000013, encoding inserted into ID on flush/reset
cnt_width, 16, width of the fetched-instruction counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
stall  input  1  hold PC and IF/ID contents this cycle
branch_taken  input  1  redirect PC to branch_target and flush IF/ID
branch_target  input  addr_width  redirect address from EX
imem_addr  output  addr_width  instruction-memory address; combinational copy of PC
imem_rdata  input  instr_width  instruction word for imem_addr, valid in the same cycle
id_pc  output  addr_width  PC of instruction held in IF/ID
id_pc_next  output  addr_width  id_pc + pc_step, for link/branch calc
id_instr  output  instr_width  instruction held in IF/ID
id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
fetch_count  output  cnt_width  number of instructions delivered to ID, saturating

Behaviour:
- Reset: rst low clears state immediately, independent of clk.
  - pc = reset_pc; id_pc = 0; id_pc_next = 0; id_instr = nop_instr; id_valid = 0; fetch_count = 0.
  - Outputs hold these values while rst is low. First fetch happens on the first rising edge after rst goes high.
- imem_addr = pc at all times. There is no registered output delay on the address.
- Per rising edge, in priority order:
  1. branch_taken = 1 (overrides stall):
     - pc <= branch_target with its low log2(pc_step) bits forced to 0.
     - id_instr <= nop_instr; id_valid <= 0; id_pc <= 0; id_pc_next <= 0.
     - fetch_count unchanged.
  2. stall = 1, branch_taken = 0: pc and all id_* outputs hold; fetch_count holds.
  3. Otherwise (advance):
     - id_pc <= pc; id_pc_next <= pc + pc_step; id_instr <= imem_rdata; id_valid <= 1.
     - pc <= pc + pc_step.
     - fetch_count <= fetch_count + 1, saturating at all-ones.
- Latency: an instruction at address A appears on id_instr one edge after pc = A with no stall or branch.
- Branch penalty:
  - The instruction at the redirect target is fetched the edge after the redirect.
  - ID sees exactly one bubble per branch_taken pulse.
  - Back-to-back branch_taken pulses give one bubble each, and each target overrides the previous one.
- Arithmetic:
  - pc + pc_step wraps modulo 2^addr_width, so all-ones-minus-3 advances to 0 with no flag.
  - id_pc_next uses the same wrap rule.
- Reset mid-operation: asynchronous clear takes effect even while stall or branch_taken is asserted. Pending inputs are ignored until rst deasserts.
- X on imem_rdata is passed through only when advancing. A stalled or flushed IF/ID never samples imem_rdata.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1, imem returns 32'h00A00093 at 0 → during reset imem_addr=0, id_valid=0, id_instr=32'h00000013; after first edge id_pc=0, id_pc_next=4, id_instr=32'h00A00093, id_valid=1, fetch_count=1.
- Sequential fetch: 4 free-running cycles from reset → imem_addr 0,4,8,12,16; id_pc 0,4,8,12; fetch_count=4.
- Stall: assert stall for 3 cycles with pc=8 → imem_addr stays 8, id_pc stays 4, id_instr unchanged, fetch_count frozen; release → id_pc=8 next edge.
- Branch plus stall: at pc=12 assert branch_taken=1, stall=1, branch_target=32'h00000103 → next edge pc=32'h100, id_valid=0, id_instr=nop; following edge id_pc=32'h100, id_valid=1.
- Wrap and saturation: with reset_pc=32'hFFFFFFF8 → PC sequence FFFFFFF8, FFFFFFFC, 0, 4, and id_pc_next of FFFFFFFC is 0. With cnt_width=2, after 5 fetches fetch_count=3.
- Async reset mid-run: drop rst between edges while pc=32'h20 and stall=1 → all outputs return to reset values before the next edge; fetch restarts at reset_pc after release.
